abro_sequencer: RTL and testbench



---
 rtl/abro_sequencer.sv | 165 ++++++++++++++++
 tb/tb_abro_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/abro_sequencer.sv
// Stimulus driver and cycle-accurate checker for the 4-state A/B/reset recogniser.
// Drives a latched step pattern on A/B and compares the recogniser's state against an internal model.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | A=B=0, waiting for start; latches seq and loads model
// S_DRIVE | A/B carry the current step's bits for one cycle
// S_GAPW  | A=B=0 for GAP cycles after a step, down-counted
// S_FINAL | A=B=0, last comparison of the run
// S_END   | done pulse, result valid, back to S_IDLE
module abro_sequencer #(
  parameter int N      = 4,
  parameter int STEPS  = 4,
  parameter int STEP_W = 2,
  parameter int GAP    = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2*STEPS-1:0] seq,
  input  logic [N-1:0]       state,
  output logic               A,
  output logic               B,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [STEP_W-1:0]  err_step,
  output logic [N-1:0]       err_state
);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_GAPW, S_FINAL, S_END} fsm_e;

  localparam logic [3:0]        GAP_LOAD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  fsm_e               fsm_q, fsm_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [2*STEPS-1:0] seq_q, seq_d;
  logic [N-1:0]       model_q, model_d;
  logic               a_q, a_d, b_q, b_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [STEP_W-1:0]  err_step_q, err_step_d;
  logic [N-1:0]       err_state_q, err_state_d;

  logic               check_en, mismatch;
  logic [STEP_W-1:0]  cur_step;
  logic [1:0]         drive_bits;

  function automatic logic [N-1:0] model_next(input logic [N-1:0] s, input logic a, input logic b);
    if (s == N'(0)) return (a && b) ? N'(1) : s;
    if (s == N'(1)) return a ? N'(2) : s;
    if (s == N'(2)) return b ? N'(3) : s;
    if (s == N'(3)) return N'(0);
    return s;
  endfunction

  always_comb begin
    fsm_d       = fsm_q;
    step_d      = step_q;
    gap_cnt_d   = gap_cnt_q;
    seq_d       = seq_q;
    model_d     = model_q;
    pass_d      = pass_q;
    err_step_d  = err_step_q;
    err_state_d = err_state_q;

    // The first drive cycle has no prior step to check against.
    check_en = ((fsm_q == S_DRIVE) && (step_q != '0)) || (fsm_q == S_GAPW) || (fsm_q == S_FINAL);
    mismatch = check_en && (state != model_q);
    cur_step = (fsm_q == S_DRIVE) ? step_q - STEP_W'(1) : step_q;

    unique case (fsm_q)
      S_IDLE: begin
        if (start) begin
          seq_d       = seq;
          model_d     = state;
          pass_d      = 1'b0;
          err_step_d  = '0;
          err_state_d = '0;
          step_d      = '0;
          fsm_d       = S_DRIVE;
        end
      end
      S_DRIVE, S_GAPW, S_FINAL: begin
        if (fsm_q != S_FINAL) model_d = model_next(model_q, a_q, b_q);
        if (mismatch) begin
          fsm_d       = S_END;
          pass_d      = 1'b0;
          err_step_d  = cur_step;
          err_state_d = state;
        end else if (fsm_q == S_DRIVE) begin
          if (GAP > 0) begin
            fsm_d     = S_GAPW;
            gap_cnt_d = GAP_LOAD;
          end else if (step_q == LAST_STEP) begin
            fsm_d = S_FINAL;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end else if (fsm_q == S_GAPW) begin
          if (gap_cnt_q == 4'd0) begin
            if (step_q == LAST_STEP) begin
              fsm_d = S_FINAL;
            end else begin
              step_d = step_q + STEP_W'(1);
              fsm_d  = S_DRIVE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end
        end else begin
          fsm_d  = S_END;
          pass_d = 1'b1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    drive_bits = 2'(seq_d >> {step_d, 1'b0});
    a_d    = (fsm_d == S_DRIVE) && drive_bits[1];
    b_d    = (fsm_d == S_DRIVE) && drive_bits[0];
    busy_d = (fsm_d == S_DRIVE) || (fsm_d == S_GAPW) || (fsm_d == S_FINAL);
    done_d = (fsm_d == S_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      step_q      <= '0;
      gap_cnt_q   <= '0;
      seq_q       <= '0;
      model_q     <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_step_q  <= '0;
      err_state_q <= '0;
    end else begin
      fsm_q       <= fsm_d;
      step_q      <= step_d;
      gap_cnt_q   <= gap_cnt_d;
      seq_q       <= seq_d;
      model_q     <= model_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_step_q  <= err_step_d;
      err_state_q <= err_state_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_step  = err_step_q;
  assign err_state = err_state_q;

endmodule

// File: tb/tb_abro_sequencer.sv
// Bench for abro_sequencer: two instances (GAP=0 and GAP=2), a per-run outcome model
// derived from the recogniser rules, and per-cycle comparison of every output.
module tb_abro_sequencer;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] seq;
  logic [3:0] st_drv;
  bit         use2;
  logic       start0, start2;

  logic       a0, b0, busy0, done0, pass0;
  logic [1:0] es0;
  logic [3:0] est0;
  logic       a2, b2, busy2, done2, pass2;
  logic [1:0] es2;
  logic [3:0] est2;

  assign start0 = start & ~use2;
  assign start2 = start & use2;

  always #5 clk = ~clk;

  abro_sequencer #(.N(4), .STEPS(4), .STEP_W(2), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .seq(seq), .state(st_drv),
    .A(a0), .B(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_step(es0), .err_state(est0)
  );

  abro_sequencer #(.N(4), .STEPS(4), .STEP_W(2), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .seq(seq), .state(st_drv),
    .A(a2), .B(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_step(es2), .err_state(est2)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          gap;
  logic [7:0]  run_seq;
  logic [3:0]  s_init;
  logic [3:0]  r_arr   [0:15];
  int          m_arr   [0:16];
  logic [10:0] exp_sig [0:31];
  logic [10:0] obs_sig [0:31];
  int          exp_done_j;

  // Recogniser transition rules, one state at a time.
  function automatic int nxt(input int s, input bit a, input bit b);
    if (s == 0) return (a && b) ? 1 : 0;
    if (s == 1) return a ? 2 : 1;
    if (s == 2) return b ? 3 : 2;
    if (s == 3) return 0;
    return s;
  endfunction

  // Expected {A,B,busy,done,pass,err_step,err_state} for each cycle offset j after start.
  function automatic void predict();
    int per, len, fi;
    logic [1:0] drv [0:15];
    logic [1:0] ab;
    logic       p;
    logic [1:0] es;
    logic [3:0] est;
    per = 1 + gap;
    len = 4 * per;
    for (int q = 0; q < 16; q++) drv[q] = 2'b00;
    for (int q = 0; q < len; q++)
      if (q % per == 0) drv[q] = run_seq[2*(q/per) +: 2];
    m_arr[0] = int'(s_init);
    for (int i = 0; i < len; i++) m_arr[i+1] = nxt(m_arr[i], drv[i][1], drv[i][0]);
    fi = 0;
    for (int i = 1; i <= len; i++)
      if (fi == 0 && int'(r_arr[i]) != m_arr[i]) fi = i;
    exp_done_j = (fi != 0) ? fi + 2 : len + 2;
    p   = (fi == 0);
    es  = (fi != 0) ? 2'((fi - 1) / per) : 2'd0;
    est = (fi != 0) ? r_arr[fi] : 4'd0;
    for (int j = 0; j < 32; j++) begin
      ab = 2'b00;
      if (j >= 1 && j <= len && j < exp_done_j) ab = drv[j-1];
      exp_sig[j] = {ab, (j >= 1 && j < exp_done_j), (j == exp_done_j),
                    (j >= exp_done_j) ? {p, es, est} : 7'd0};
    end
  endfunction

  function automatic logic [10:0] cur_sig();
    return use2 ? {a2, b2, busy2, done2, pass2, es2, est2}
                : {a0, b0, busy0, done0, pass0, es0, est0};
  endfunction

  function automatic void ideal_r();
    predict();
    for (int i = 0; i < 16; i++) r_arr[i] = (i <= 16) ? 4'(m_arr[i]) : 4'd0;
  endfunction

  // Runs one start..done+1 window; state in cycle t+j is r_arr[j-1].
  task automatic do_run(input bit disturb);
    predict();
    @(negedge clk);
    start  = 1'b1;
    seq    = run_seq;
    st_drv = s_init;
    for (int j = 1; j <= exp_done_j + 1; j++) begin
      @(negedge clk);
      obs_sig[j] = cur_sig();
      start  = (disturb && j < exp_done_j) ? 1'($urandom % 2) : 1'b0;
      if (disturb) seq = 8'($urandom);
      st_drv = r_arr[j-1];
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    seq   = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      n_assert++;
      if ({a0, b0, busy0, done0, pass0, es0, est0, a2, b2, busy2, done2, pass2, es2, est2} !== 22'd0) begin
        n_fail++;
        $display("FAIL reset_state got %b_%b want all zero", cur_sig(),
                 {a2, b2, busy2, done2, pass2, es2, est2});
      end
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pass_gap0();
    use2 = 0; gap = 0; run_seq = 8'b00_01_10_11; s_init = 4'd0;
    ideal_r();
    do_run(1'b0);
    for (int j = 1; j <= exp_done_j + 1; j++) begin
      n_assert++;
      if (obs_sig[j] !== exp_sig[j]) begin
        n_fail++;
        $display("FAIL pass_gap0 cyc t+%0d {A,B,busy,done,pass,es,est} got %b want %b", j, obs_sig[j], exp_sig[j]);
      end
    end
  endtask

  task automatic test_stuck();
    use2 = 0; gap = 0; run_seq = 8'b00_01_10_11; s_init = 4'd0;
    r_arr[0] = 4'd0;
    for (int i = 1; i < 16; i++) r_arr[i] = 4'd1;
    do_run(1'b0);
    for (int j = 1; j <= exp_done_j + 1; j++) begin
      n_assert++;
      if (obs_sig[j] !== exp_sig[j]) begin
        n_fail++;
        $display("FAIL stuck_at_1 cyc t+%0d got %b want %b", j, obs_sig[j], exp_sig[j]);
      end
    end
  endtask

  task automatic test_gap2();
    use2 = 1; gap = 2; run_seq = 8'b00_00_00_11; s_init = 4'd0;
    ideal_r();
    do_run(1'b0);
    for (int j = 1; j <= exp_done_j + 1; j++) begin
      n_assert++;
      if (obs_sig[j] !== exp_sig[j]) begin
        n_fail++;
        $display("FAIL gap2 cyc t+%0d got %b want %b", j, obs_sig[j], exp_sig[j]);
      end
    end
  endtask

  task automatic test_out_of_range();
    use2 = 0; gap = 0; run_seq = 8'hFF; s_init = 4'd5;
    for (int i = 0; i < 16; i++) r_arr[i] = 4'd5;
    do_run(1'b0);
    for (int j = 1; j <= exp_done_j + 1; j++) begin
      n_assert++;
      if (obs_sig[j] !== exp_sig[j]) begin
        n_fail++;
        $display("FAIL out_of_range cyc t+%0d got %b want %b", j, obs_sig[j], exp_sig[j]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    for (int k = 0; k < 2; k++) begin
      use2 = 0; gap = 0; run_seq = 8'b00_01_10_11; s_init = 4'd0;
      ideal_r();
      if (k == 1) for (int i = 2; i < 16; i++) r_arr[i] = 4'd1;
      do_run(1'b1);
      for (int j = 1; j <= exp_done_j + 1; j++) begin
        n_assert++;
        if (obs_sig[j] !== exp_sig[j]) begin
          n_fail++;
          $display("FAIL busy_ignore run %0d cyc t+%0d got %b want %b", k, j, obs_sig[j], exp_sig[j]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    use2 = 0; gap = 0; run_seq = 8'b00_01_10_11; s_init = 4'd0;
    @(negedge clk); start = 1'b1; seq = run_seq; st_drv = 4'd0;
    @(negedge clk); start = 1'b0; st_drv = 4'd0;
    @(negedge clk); st_drv = 4'd1;
    @(negedge clk); reset = 1'b1; st_drv = 4'd2;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_assert++;
      if (cur_sig() !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_midrun cyc t+%0d got %b want 0", 4 + k, cur_sig());
      end
      @(negedge clk);
    end
    ideal_r();
    do_run(1'b0);
    for (int j = 1; j <= exp_done_j + 1; j++) begin
      n_assert++;
      if (obs_sig[j] !== exp_sig[j]) begin
        n_fail++;
        $display("FAIL after_reset_run cyc t+%0d got %b want %b", j, obs_sig[j], exp_sig[j]);
      end
    end
  endtask

  task automatic test_random();
    int len, fi;
    bit dis;
    for (int n = 0; n < 40; n++) begin
      use2    = ($urandom % 2) == 1;
      gap     = use2 ? 2 : 0;
      run_seq = 8'($urandom);
      s_init  = ($urandom % 4 == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      dis     = ($urandom % 3) == 0;
      ideal_r();
      len = 4 * (1 + gap);
      if ($urandom % 2 == 1) begin
        fi = $urandom_range(1, len);
        r_arr[fi] = r_arr[fi] ^ 4'($urandom_range(1, 15));
      end
      do_run(dis);
      for (int j = 1; j <= exp_done_j + 1; j++) begin
        n_assert++;
        if (obs_sig[j] !== exp_sig[j]) begin
          n_fail++;
          $display("FAIL random run %0d gap %0d seq %h cyc t+%0d got %b want %b",
                   n, gap, run_seq, j, obs_sig[j], exp_sig[j]);
        end
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    seq    = 8'h00;
    st_drv = 4'd0;
    use2   = 0;
    gap    = 0;
    for (int i = 0; i < 16; i++) r_arr[i] = 4'd0;
    test_reset();
    test_pass_gap0();
    test_stuck();
    test_gap2();
    test_out_of_range();
    test_busy_ignore();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
